// File: rtl/sha256_pkg.sv
// ============================================================================
// sha256_pkg : shared types and constants for the SHA-256 work dispatcher
// Rev 1.0
// ============================================================================
`default_nettype none

package sha256_pkg;

  typedef enum logic [1:0] {
    ST_RECV   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_SEND   = 2'd3
  } dispatch_state_t;

  localparam int WORK_BYTES = 76;
  localparam int RESP_BYTES = 5;

  localparam logic [7:0] RESP_OK      = 8'hA5;
  localparam logic [7:0] RESP_TIMEOUT = 8'h5A;

  localparam int MIDSTATE_W = 256;
  localparam int DATA_W     = 96;
  localparam int TARGET_W   = 256;
  localparam int FRAME_W    = MIDSTATE_W + DATA_W + TARGET_W;

endpackage

`default_nettype wire

// File: rtl/sha256_work_dispatcher_byte_serializer.sv
// ============================================================================
// byte_serializer : emits {code, word[31:24..7:0]} as 5 valid/ready bytes
// Rev 1.0
// ============================================================================
`default_nettype none

module byte_serializer
  import sha256_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [7:0]  code_i,
  input  logic [31:0] word_i,
  output logic [7:0]  out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        last_xfer_o
);

  localparam logic [2:0] LAST_IDX = 3'(RESP_BYTES - 1);

  logic [7:0]  data_q;
  logic        valid_q;
  logic [31:0] word_q;
  logic [2:0]  idx_q;

  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;
  assign last_xfer_o = valid_q & out_ready_i & (idx_q == LAST_IDX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      word_q  <= '0;
      idx_q   <= '0;
    end else if (load_i) begin
      data_q  <= code_i;
      valid_q <= 1'b1;
      word_q  <= word_i;
      idx_q   <= '0;
    end else if (valid_q && out_ready_i) begin
      if (idx_q == LAST_IDX) begin
        valid_q <= 1'b0;
        data_q  <= 8'h00;
      end else begin
        // Remaining nonce bytes leave MSB first from the top of word_q.
        data_q <= word_q[31:24];
        word_q <= {word_q[23:0], 8'h00};
        idx_q  <= idx_q + 3'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sha256_work_dispatcher.sv
// ============================================================================
// sha256_work_dispatcher : byte-stream front end for SHA256_controller
// Optional WAIT timeout enabled by SHA256_DISPATCH_TIMEOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module sha256_work_dispatcher
  import sha256_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  calculate,
  output logic [MIDSTATE_W-1:0] midstate,
  output logic [DATA_W-1:0]     data,
  output logic [TARGET_W-1:0]   target,
  input  logic [31:0]           good_nonce,
  input  logic                  done
);

  localparam logic [6:0] LAST_BYTE = 7'(WORK_BYTES - 1);

  dispatch_state_t    state_q;
  logic [6:0]         byte_cnt_q;
  logic [FRAME_W-1:0] frame_q;
  logic               in_ready_q;
  logic               calculate_q;
  logic               done_q;

  logic               done_edge_w;
  logic               timeout_w;
  logic               load_w;
  logic               last_xfer_w;
  logic [7:0]         code_w;
  logic [31:0]        nonce_w;

  // Only a fresh rising edge counts, so a level left over from an earlier job is ignored.
  assign done_edge_w = done & ~done_q;

`ifdef SHA256_DISPATCH_TIMEOUT_EN
  logic [31:0] wait_cnt_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)                wait_cnt_q <= '0;
    else if (state_q != ST_WAIT) wait_cnt_q <= '0;
    else                        wait_cnt_q <= wait_cnt_q + 32'd1;
  end

  assign timeout_w = (wait_cnt_q + 32'd1 >= TIMEOUT_CYCLES);
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout_w = 1'b0;
`endif

  assign load_w  = (state_q == ST_WAIT) && (done_edge_w || timeout_w);
  assign code_w  = done_edge_w ? RESP_OK : RESP_TIMEOUT;
  assign nonce_w = done_edge_w ? good_nonce : 32'h0;

  byte_serializer u_ser (
    .clk_i       (CLOCK_50),
    .rst_ni      (resetn),
    .load_i      (load_w),
    .code_i      (code_w),
    .word_i      (nonce_w),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .last_xfer_o (last_xfer_w)
  );

  assign in_ready  = in_ready_q;
  assign calculate = calculate_q;
  assign midstate  = frame_q[FRAME_W-1 -: MIDSTATE_W];
  assign data      = frame_q[TARGET_W +: DATA_W];
  assign target    = frame_q[TARGET_W-1:0];

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_RECV;
      byte_cnt_q  <= '0;
      frame_q     <= '0;
      in_ready_q  <= 1'b1;
      calculate_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= done;
      calculate_q <= 1'b0;
      case (state_q)
        ST_RECV: begin
          if (in_valid && in_ready_q) begin
            frame_q <= {frame_q[FRAME_W-9:0], in_data};
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_q  <= '0;
              in_ready_q  <= 1'b0;
              calculate_q <= 1'b1;
              state_q     <= ST_LAUNCH;
            end else begin
              byte_cnt_q <= byte_cnt_q + 7'd1;
            end
          end
        end
        ST_LAUNCH: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (load_w) state_q <= ST_SEND;
        end
        ST_SEND: begin
          // Reopen the inbound port right as the final response byte leaves.
          if (last_xfer_w) begin
            in_ready_q <= 1'b1;
            state_q    <= ST_RECV;
          end
        end
        default: state_q <= ST_RECV;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sha256_work_dispatcher.sv
// ============================================================================
// tb_sha256_work_dispatcher : directed + randomized bench with frame model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sha256_work_dispatcher;

  logic         CLOCK_50 = 1'b0;
  logic         resetn;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         calculate;
  logic [255:0] midstate;
  logic [95:0]  data;
  logic [255:0] target;
  logic [31:0]  good_nonce;
  logic         done;

  int errors = 0;
  int checks = 0;
  int calc_cnt = 0;

  logic [7:0]   fb [76];
  logic [255:0] exp_mid;
  logic [95:0]  exp_data;
  logic [255:0] exp_tgt;

  sha256_work_dispatcher #(.TIMEOUT_CYCLES(32'd100)) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .calculate  (calculate),
    .midstate   (midstate),
    .data       (data),
    .target     (target),
    .good_nonce (good_nonce),
    .done       (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) if (calculate === 1'b1) calc_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Byte i of the work unit maps to a fixed field position, MSB first.
  task automatic frame_from_vectors(input logic [255:0] m, input logic [95:0] d, input logic [255:0] t);
    exp_mid = m; exp_data = d; exp_tgt = t;
    for (int i = 0; i < 32; i++) fb[i] = m[255-8*i -: 8];
    for (int i = 0; i < 12; i++) fb[32+i] = d[95-8*i -: 8];
    for (int i = 0; i < 32; i++) fb[44+i] = t[255-8*i -: 8];
  endtask

  task automatic frame_random();
    for (int i = 0; i < 76; i++) fb[i] = 8'($urandom);
    for (int i = 0; i < 32; i++) exp_mid[255-8*i -: 8] = fb[i];
    for (int i = 0; i < 12; i++) exp_data[95-8*i -: 8] = fb[32+i];
    for (int i = 0; i < 32; i++) exp_tgt[255-8*i -: 8] = fb[44+i];
  endtask

  task automatic send_bytes(input int n, input bit gaps);
    int guard;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      in_data  = fb[i];
      in_valid = 1'b1;
      guard = 0;
      while (in_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
      if (in_ready !== 1'b1) chk("in_ready_wait", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Called one cycle after the last byte edge; leaves the bench in WAIT cycle 1.
  task automatic check_launch(input string tag);
    chk({tag, "_calc_hi"}, calculate, 1);
    chk({tag, "_in_ready_lo"}, in_ready, 0);
    chk({tag, "_midstate"}, midstate, exp_mid);
    chk({tag, "_data"}, data, exp_data);
    chk({tag, "_target"}, target, exp_tgt);
    tick();
    chk({tag, "_calc_lo"}, calculate, 0);
  endtask

  task automatic respond(input logic [31:0] nonce);
    good_nonce = nonce;
    done = 1'b1;
    tick();
    chk("resp_valid_first", out_valid, 1);
    chk("resp_code_first", out_data, 8'hA5);
    done = 1'b0;
  endtask

  task automatic collect(input string tag, input logic [39:0] expb, input bit bp);
    logic [7:0] rx [5];
    logic [7:0] held;
    int got, guard;
    bit stalled;
    got = 0; guard = 0; stalled = 0; held = 8'h00;
    while (got < 5 && guard < 100) begin
      out_ready = bp ? ((guard % 4 == 0) || (guard % 4 == 3)) : 1'b1;
      if (stalled) begin
        chk({tag, "_hold_data"}, out_data, held);
        chk({tag, "_hold_valid"}, out_valid, 1);
      end
      stalled = 0;
      if (out_valid === 1'b1) begin
        if (out_ready) begin rx[got] = out_data; got++; end
        else begin stalled = 1; held = out_data; end
      end
      tick();
      guard++;
    end
    chk({tag, "_count"}, got, 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("%s_byte%0d", tag, i), (i < got) ? rx[i] : 8'hxx, expb[39-8*i -: 8]);
    chk({tag, "_valid_after"}, out_valid, 0);
    chk({tag, "_in_ready_after"}, in_ready, 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 8'h00);
    chk({tag, "_calc"}, calculate, 0);
    chk({tag, "_midstate"}, midstate, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_target"}, target, 0);
  endtask

  initial begin
    logic [31:0] nonce;
    int c0;
    resetn = 1'b0; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b1;
    good_nonce = 32'h0; done = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    resetn = 1'b1;
    tick();

    // Nominal job with known vectors, then bytes offered during WAIT
    frame_from_vectors(
      256'h9fd47d57_1a2b3c4d_5e6f7081_92a3b4c5_d6e7f809_1b2c3d4e_5f607182_74b4c79d,
      96'h1a65600e_a6c8cb4d_b3936a1a,
      256'h00000000_00006a93_b3000000_00000000_00000000_00000000_00000000_00000000);
    c0 = calc_cnt;
    send_bytes(76, 0);
    check_launch("nominal");
    chk("nominal_one_calc", calc_cnt - c0, 1);
    in_data = 8'hEE; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wait_in_ready_%0d", i), in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    chk("wait_frame_held", midstate, exp_mid);
    respond(32'h12345678);
    collect("nominal", 40'hA5_12345678, 0);

    // Random frame with input gaps and output backpressure
    frame_random();
    send_bytes(76, 1);
    check_launch("gaps");
    nonce = $urandom;
    repeat (3) tick();
    respond(nonce);
    collect("bp", {8'hA5, nonce}, 1);

    // Stale done level held through LAUNCH and WAIT
    frame_random();
    done = 1'b1;
    good_nonce = 32'hDEADBEEF;
    send_bytes(76, 0);
    check_launch("stale");
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("stale_no_resp_%0d", i), out_valid, 0);
      tick();
    end
    done = 1'b0;
    tick();
    chk("stale_no_resp_low", out_valid, 0);
    nonce = $urandom;
    respond(nonce);
    collect("stale", {8'hA5, nonce}, 0);

    // Reset after 40 bytes, then a full new frame
    frame_random();
    send_bytes(40, 0);
    resetn = 1'b0;
    tick(); tick();
    check_reset_values("midframe_rst");
    resetn = 1'b1;
    tick();
    c0 = calc_cnt;
    frame_random();
    send_bytes(76, 1);
    check_launch("after_rst");
    chk("after_rst_one_calc", calc_cnt - c0, 1);
    nonce = $urandom;
    respond(nonce);
    collect("after_rst", {8'hA5, nonce}, 0);

    // Reset in WAIT abandons the job; a later done edge produces nothing
    frame_random();
    send_bytes(76, 0);
    check_launch("wait_rst");
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    done = 1'b1;
    good_nonce = 32'hCAFEF00D;
    tick(); tick();
    chk("wait_rst_no_resp", out_valid, 0);
    chk("wait_rst_in_ready", in_ready, 1);
    done = 1'b0;
    tick();

`ifdef SHA256_DISPATCH_TIMEOUT_EN
    frame_random();
    send_bytes(76, 0);
    check_launch("timeout");
    repeat (99) tick();
    chk("timeout_not_yet", out_valid, 0);
    tick();
    chk("timeout_valid", out_valid, 1);
    collect("timeout", 40'h5A_00000000, 0);
`else
    frame_random();
    send_bytes(76, 0);
    check_launch("no_timeout");
    repeat (150) tick();
    chk("no_timeout_idle", out_valid, 0);
    chk("no_timeout_in_ready", in_ready, 0);
    nonce = $urandom;
    respond(nonce);
    collect("no_timeout", {8'hA5, nonce}, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
